// File: rtl/mult32_seq_ctrl.sv
// Shift-add sequencer for a 32x32 unsigned multiply around an external combinational adder.
// Result is valid 32 cycles after operand accept and is held in DONE until Res_rdy is seen; Start is only accepted in IDLE.
module mult32_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Clear,
  input  logic               Start,
  output logic               Start_rdy,
  input  logic [WIDTH-1:0]   Op_A,
  input  logic [WIDTH-1:0]   Op_B,
  output logic [WIDTH-1:0]   Add_A,
  output logic [WIDTH-1:0]   Add_B,
  output logic               Add_Cin,
  input  logic [WIDTH-1:0]   Add_Sum,
  input  logic               Add_Cout,
  output logic               Busy,
  output logic               Res_valid,
  input  logic               Res_rdy,
  output logic [2*WIDTH-1:0] Product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (Clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (Start) state_nxt = RUN;
        RUN:     if (cnt == LAST_ITER) state_nxt = DONE;
        DONE:    if (Res_rdy) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Clear only rewinds the counter; operand and product registers keep their contents.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
    end else if (Clear) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            mcand <= Op_A;
            prod  <= {{WIDTH{1'b0}}, Op_B};
            cnt   <= '0;
          end
        end
        RUN: begin
          // Carry-out becomes the new MSB so the full 64-bit product survives the shift.
          prod <= {Add_Cout, Add_Sum, prod[WIDTH-1:1]};
          cnt  <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign Add_A     = prod[2*WIDTH-1:WIDTH];
  assign Add_B     = prod[0] ? mcand : '0;
  assign Add_Cin   = 1'b0;
  assign Start_rdy = (state == IDLE);
  assign Busy      = (state == RUN);
  assign Res_valid = (state == DONE);
  assign Product   = prod;

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// Bench for mult32_seq_ctrl: behavioural adder, scoreboard of expected products, latency and control checks.
module tb_mult32_seq_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Clear = 1'b0;
  logic        Start = 1'b0;
  logic        Start_rdy;
  logic [31:0] Op_A = '0;
  logic [31:0] Op_B = '0;
  logic [31:0] Add_A, Add_B, Add_Sum;
  logic        Add_Cin, Add_Cout;
  logic        Busy, Res_valid;
  logic        Res_rdy = 1'b0;
  logic [63:0] Product;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc_cnt = 0;
  int          t_acc = 0;
  logic [63:0] sb_q[$];

  mult32_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Clear(Clear), .Start(Start), .Start_rdy(Start_rdy),
    .Op_A(Op_A), .Op_B(Op_B), .Add_A(Add_A), .Add_B(Add_B), .Add_Cin(Add_Cin),
    .Add_Sum(Add_Sum), .Add_Cout(Add_Cout), .Busy(Busy), .Res_valid(Res_valid),
    .Res_rdy(Res_rdy), .Product(Product)
  );

  assign {Add_Cout, Add_Sum} = {1'b0, Add_A} + {1'b0, Add_B} + {32'b0, Add_Cin};

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one operand pair for a single cycle; the accept edge is the next posedge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
    @(negedge Clk);
    chk("start_rdy_idle", Start_rdy, 1'b1);
    Start = 1'b1; Op_A = a; Op_B = b;
    if (push) sb_q.push_back({32'h0, a} * {32'h0, b});
    @(negedge Clk);
    t_acc = cyc_cnt;
    Start = 1'b0;
    chk("busy_after_accept", Busy, 1'b1);
  endtask

  // Wait for Res_valid, check latency and product, then accept the result.
  task automatic wait_done(input string tag);
    int   guard;
    bit   rdy_seen;
    logic [63:0] exp;
    guard = 0;
    rdy_seen = 1'b0;
    while (!Res_valid && guard < 200) begin
      if (Start_rdy) rdy_seen = 1'b1;
      @(negedge Clk);
      guard++;
    end
    if (!Res_valid) begin
      chk({tag, "_timeout"}, 1'b0, 1'b1);
      return;
    end
    chk({tag, "_latency"}, 64'(cyc_cnt - t_acc), 64'd32);
    chk({tag, "_rdy_low_in_run"}, rdy_seen, 1'b0);
    if (sb_q.size() == 0) begin
      chk({tag, "_unexpected_result"}, 1'b1, 1'b0);
    end else begin
      exp = sb_q.pop_front();
      chk({tag, "_product"}, Product, exp);
    end
    Res_rdy = 1'b1;
    @(negedge Clk);
    Res_rdy = 1'b0;
    chk({tag, "_back_to_idle"}, {Start_rdy, Res_valid, Busy}, 3'b100);
  endtask

  initial begin
    logic [63:0] held;
    bit          unstable;
    logic [31:0] ra, rb;

    #12;
    chk("reset_state", {Start_rdy, Busy, Res_valid}, 3'b100);
    chk("reset_product", Product, 64'h0);
    chk("reset_add_cin", Add_Cin, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;

    start_op(32'd3, 32'd5, 1'b1);                 wait_done("m3x5");
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done("max");
    chk("max_literal", Product, 64'hFFFF_FFFE_0000_0001);
    start_op(32'h8000_0000, 32'h2, 1'b1);         wait_done("msb");
    chk("msb_literal", Product, 64'h0000_0001_0000_0000);
    start_op(32'h0, 32'h1234_5678, 1'b1);         wait_done("zero");
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      start_op(ra, rb, 1'b1); wait_done("rand");
    end

    // Start pulsed mid-run must be ignored.
    start_op(32'd3, 32'd5, 1'b1);
    repeat (9) @(negedge Clk);
    chk("start_rdy_run10", Start_rdy, 1'b0);
    Start = 1'b1; Op_A = 32'd7; Op_B = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    wait_done("ignore_start");

    // Result held while Res_rdy stays low.
    start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    repeat (40) begin
      if (!Res_valid) @(negedge Clk);
    end
    chk("hold_valid", Res_valid, 1'b1);
    held = Product;
    unstable = 1'b0;
    repeat (20) begin
      @(negedge Clk);
      if (!Res_valid || Product !== held) unstable = 1'b1;
    end
    chk("hold_stable", unstable, 1'b0);
    chk("hold_product", held, sb_q.size() > 0 ? sb_q[0] : 64'hX);
    void'(sb_q.pop_front());
    Res_rdy = 1'b1;
    @(negedge Clk);
    Res_rdy = 1'b0;
    chk("hold_release", {Start_rdy, Res_valid}, 2'b10);
    start_op(32'd3, 32'd5, 1'b1); wait_done("after_hold");

    // Clear mid-run aborts without a result.
    start_op(32'd9, 32'd9, 1'b0);
    repeat (14) @(negedge Clk);
    Clear = 1'b1;
    @(negedge Clk);
    Clear = 1'b0;
    chk("clear_idle", {Start_rdy, Busy, Res_valid}, 3'b100);
    start_op(32'd3, 32'd5, 1'b1); wait_done("after_clear");

    // Async reset mid-run returns to reset values immediately.
    start_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
    repeat (19) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_ctrl", {Start_rdy, Busy, Res_valid}, 3'b100);
    chk("arst_product", Product, 64'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    start_op(32'd3, 32'd5, 1'b1); wait_done("after_reset");

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
